lfsr_gen: RTL

Parametrised linear-feedback shift register generalising the fixed 4-bit LFSR to any width from 3 to 32, with Fibonacci or Galois mode, run-time seed loading, zero-seed protection and on-chip period measurement. Used as a pseudo-random stimulus and scrambler source inside sequential-logic projects. It is also self-checking: wrap detection and a period counter let a bench confirm maximal length without an external reference model.

---
 rtl/lfsr_pkg.sv | 70 +++++++
 rtl/lfsr_next.sv | 27 ++
 rtl/lfsr_gen.sv | 98 +++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants, maximal-length tap table and parameter sanity checks
// for the parametrised LFSR generator.
package lfsr_pkg;

    localparam int MODE_FIB = 0;
    localparam int MODE_GAL = 1;

    // Builds a mask from up to four exponents; bit e-1 holds the x^e coefficient.
    function automatic logic [31:0] tap_bits(int a, int b, int c, int d);
        logic [31:0] m;
        m = '0;
        m[a-1] = 1'b1;
        m[b-1] = 1'b1;
        if (c > 0) m[c-1] = 1'b1;
        if (d > 0) m[d-1] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] max_taps(int width);
        logic [31:0] m;
        m = '0;
        case (width)
            3:  m = tap_bits(3, 2, 0, 0);
            4:  m = tap_bits(4, 3, 0, 0);
            5:  m = tap_bits(5, 3, 0, 0);
            6:  m = tap_bits(6, 5, 0, 0);
            7:  m = tap_bits(7, 6, 0, 0);
            8:  m = tap_bits(8, 6, 5, 4);
            9:  m = tap_bits(9, 5, 0, 0);
            10: m = tap_bits(10, 7, 0, 0);
            11: m = tap_bits(11, 9, 0, 0);
            12: m = tap_bits(12, 6, 4, 1);
            13: m = tap_bits(13, 4, 3, 1);
            14: m = tap_bits(14, 5, 3, 1);
            15: m = tap_bits(15, 14, 0, 0);
            16: m = tap_bits(16, 15, 13, 4);
            17: m = tap_bits(17, 14, 0, 0);
            18: m = tap_bits(18, 11, 0, 0);
            19: m = tap_bits(19, 6, 2, 1);
            20: m = tap_bits(20, 17, 0, 0);
            21: m = tap_bits(21, 19, 0, 0);
            22: m = tap_bits(22, 21, 0, 0);
            23: m = tap_bits(23, 18, 0, 0);
            24: m = tap_bits(24, 23, 22, 17);
            25: m = tap_bits(25, 22, 0, 0);
            26: m = tap_bits(26, 6, 2, 1);
            27: m = tap_bits(27, 5, 2, 1);
            28: m = tap_bits(28, 25, 0, 0);
            29: m = tap_bits(29, 27, 0, 0);
            30: m = tap_bits(30, 6, 4, 1);
            31: m = tap_bits(31, 28, 0, 0);
            32: m = tap_bits(32, 22, 2, 1);
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic bit width_ok(int width);
        return (width >= 3) && (width <= 32);
    endfunction

    function automatic bit taps_ok(int width, logic [31:0] taps);
        return taps[width-1];
    endfunction

    function automatic bit seed_ok(logic [31:0] seed);
        return seed != '0;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational one-step advance of an LFSR state in Fibonacci or Galois form.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter int               MODE  = MODE_FIB,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(max_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next
);

    generate
        if (MODE == MODE_GAL) begin : g_gal
            logic msb;
            assign msb     = state[WIDTH-1];
            assign next[0] = msb;
            // Each tapped stage folds the outgoing MSB into the shifted bit.
            for (genvar gi = 1; gi < WIDTH; gi++) begin : g_bit
                assign next[gi] = state[gi-1] ^ (msb & TAPS[gi-1]);
            end
        end else begin : g_fib
            assign next = {state[WIDTH-2:0], ^(state & TAPS)};
        end
    endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// LFSR generator with seed loading, zero-seed protection, wrap detection
// and a saturating period counter.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter int               MODE  = MODE_FIB,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(max_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] lfsr,
    output logic             serial_out,
    output logic             wrap,
    output logic             seed_err,
    output logic [WIDTH-1:0] period
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be within 3..32");
    end
    if (!taps_ok(WIDTH, 32'(TAPS))) begin : g_bad_taps
        $error("lfsr_gen: TAPS[WIDTH-1] must be 1");
    end
    if (!seed_ok(32'(SEED))) begin : g_bad_seed
        $error("lfsr_gen: SEED must be nonzero");
    end

    logic [WIDTH-1:0] lfsr_reg;
    logic [WIDTH-1:0] active_seed_reg;
    logic [WIDTH-1:0] step_cnt_reg;
    logic [WIDTH-1:0] period_reg;
    logic             wrap_reg;
    logic             seed_err_reg;
    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] cnt_inc;

    lfsr_next #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .TAPS  (TAPS)
    ) u_next (
        .state (lfsr_reg),
        .next  (step_next)
    );

    // A full cycle never exceeds 2^WIDTH-1, so saturation only guards odd TAPS.
    assign cnt_inc = (&step_cnt_reg) ? step_cnt_reg : step_cnt_reg + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg        <= SEED;
            active_seed_reg <= SEED;
            step_cnt_reg    <= '0;
            period_reg      <= '0;
            wrap_reg        <= 1'b0;
            seed_err_reg    <= 1'b0;
        end else if (load) begin
            step_cnt_reg <= '0;
            wrap_reg     <= 1'b0;
            if (seed_in == '0) begin
                // Substitute 1 so the all-zero lock-up state is unreachable.
                lfsr_reg        <= WIDTH'(1);
                active_seed_reg <= WIDTH'(1);
                seed_err_reg    <= 1'b1;
            end else begin
                lfsr_reg        <= seed_in;
                active_seed_reg <= seed_in;
                seed_err_reg    <= 1'b0;
            end
        end else if (enable) begin
            lfsr_reg     <= step_next;
            seed_err_reg <= 1'b0;
            if (step_next == active_seed_reg) begin
                wrap_reg     <= 1'b1;
                period_reg   <= cnt_inc;
                step_cnt_reg <= '0;
            end else begin
                wrap_reg     <= 1'b0;
                step_cnt_reg <= cnt_inc;
            end
        end else begin
            wrap_reg     <= 1'b0;
            seed_err_reg <= 1'b0;
        end
    end

    assign lfsr       = lfsr_reg;
    assign serial_out = lfsr_reg[WIDTH-1];
    assign wrap       = wrap_reg;
    assign seed_err   = seed_err_reg;
    assign period     = period_reg;

endmodule
